shift_add_mul_ctrl: RTL and testbench

Multi-cycle unsigned multiplier sequencer for the miniRISC ALU. It computes a WIDTH×WIDTH unsigned product by radix-2 shift-and-add. It does not contain its own adder: each cycle it drives the operands of the existing WIDTH-bit lookahead-carry adder through a dedicated port set and consumes its sum and carry-out. It sits beside the ALU and owns the adder only while `busy` is high.

---
 rtl/shift_add_mul_ctrl.sv | 62 ++++++
 tb/tb_shift_add_mul_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: radix-2 shift-and-add multiplier sequencer driving an external WIDTH-bit adder
module shift_add_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0] count;
  logic last;
  assign last = count == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = start ? S_RUN : S_IDLE;
      S_RUN:  state_nx = last ? S_DONE : S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    busy    = state == S_RUN;
    done    = state == S_DONE;
    add_a   = busy ? p[2*WIDTH-1:WIDTH] : '0;
    add_b   = (busy && p[0]) ? mcand : '0;
    add_cin = 1'b0;
    product = p;
  end
  // Each RUN cycle folds the adder result back in, shifted right by one with the carry as new MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      mcand <= '0;
      count <= '0;
    end else if (state == S_IDLE && start) begin
      p     <= {{WIDTH{1'b0}}, op_b};
      mcand <= op_a;
      count <= '0;
    end else if (state == S_RUN) begin
      p     <= {add_cout, add_sum, p[WIDTH-1:1]};
      count <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl: scoreboard bench with a behavioural adder closing the datapath loop
module tb_shift_add_mul_ctrl;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] op_a = '0, op_b = '0, add_a, add_b, add_sum;
  logic busy, done, add_cin, add_cout;
  logic [2*W-1:0] product;
  int checks = 0, failures = 0, cyc = 0, t_acc = 0, busy_cnt = 0, prev_done = -1, dones = 0;
  bit bb = 0, zero_b = 0;
  logic [2*W-1:0] sb[$];
  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("add_cin", 64'(add_cin), 64'd0);
    if (busy) busy_cnt++;
    else chk("adder_idle", {add_a, add_b}, 64'd0);
    if (zero_b && busy) chk("add_b_zero", 64'(add_b), 64'd0);
    if (done) begin
      dones++;
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else chk("product", product, sb.pop_front());
      chk("latency", 64'(cyc - t_acc), 64'(W));
      chk("busy_cycles", 64'(busy_cnt), 64'(W));
      chk("busy_in_done", 64'(busy), 64'd0);
      if (bb && prev_done >= 0) chk("spacing", 64'(cyc - prev_done), 64'(W + 2));
      prev_done = cyc;
    end
  end
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'd0, 64'd1);
    op_a = a;
    op_b = b;
    start = 1;
    sb.push_back(64'(a) * 64'(b));
    @(posedge clk);
    #1;
    t_acc = cyc;
    busy_cnt = 0;
    chk("accept_busy", 64'(busy), 64'd1);
    if (!hold) start = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((busy || done || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_adder", {add_a, add_b}, 64'd0);
    rst = 0;
    do_mul(3, 5, 0);
    drain();
    repeat (4) @(negedge clk);
    chk("product_held", product, 64'h0000_0000_0000_000F);
    do_mul('1, '1, 0);
    drain();
    chk("max_product", product, 64'hFFFF_FFFE_0000_0001);
    zero_b = 1;
    do_mul(32'hDEAD_BEEF, 0, 0);
    drain();
    zero_b = 0;
    d0 = dones;
    do_mul(6, 9, 0);
    repeat (5) @(negedge clk);
    op_a = 7;
    op_b = 7;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 64'd0, 64'd1);
    start = 1;
    @(negedge clk);
    start = 0;
    drain();
    repeat (5) @(negedge clk);
    chk("single_done", 64'(dones - d0), 64'd1);
    chk("product_54", product, 64'd54);
    do_mul(7, 7, 0);
    drain();
    chk("product_49", product, 64'd49);
    do_mul(32'h1234, 32'h5678, 0);
    repeat (10) @(negedge clk);
    rst = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_adder", {add_a, add_b}, 64'd0);
    rst = 0;
    d0 = dones;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", 64'(dones), 64'(d0));
    do_mul(32'h1234, 32'h5678, 0);
    drain();
    chk("product_after_rst", product, 64'h0626_0060);
    bb = 1;
    prev_done = -1;
    for (int i = 0; i < 1200; i++) do_mul($urandom(), $urandom(), 1);
    start = 0;
    drain();
    bb = 0;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
